redun_to_bin: RTL and testbench

Converts a redundant-form residue (NUM_WRDS words of WRD_BITS+1 bits, as produced by the modular squarer) into a canonical binary integer in [0, P). It is the exit stage after the squaring loop: it collapses the per-word carry bits over several cycles, then applies a fixed number of conditional subtractions of P. It has valid/ready handshakes on both sides, so the squarer's o_mul/o_val can be captured and held until the host reads the result.

---
 rtl/redun_mont_pkg.sv | 27 ++
 rtl/redun_chunk_addsub.sv | 38 +++
 rtl/redun_to_bin.sv | 161 ++++++++++++++++
 tb/tb_redun_to_bin.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/redun_mont_pkg.sv
// Shared types and constants for the redundant-form Montgomery datapath.
// redun_value() is a simulation reference for the integer a redundant word array encodes.
package redun_mont_pkg;

    localparam int NUM_WRDS = 4;
    localparam int WRD_BITS = 16;
    localparam logic [NUM_WRDS*WRD_BITS-1:0] P = 64'h3123_4567_89AB_CDEF;

    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;
    typedef logic [NUM_WRDS*WRD_BITS-1:0]    bin_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_CARRY = 4'b0010,
        ST_SUB   = 4'b0100,
        ST_DONE  = 4'b1000
    } r2b_state_t;

    function automatic logic [NUM_WRDS*WRD_BITS+1:0] redun_value(input redun0_t r);
        logic [NUM_WRDS*WRD_BITS+1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_WRDS; i++)
            acc += (NUM_WRDS*WRD_BITS+2)'(r[i]) << (i*WRD_BITS);
        return acc;
    endfunction

endpackage

// File: rtl/redun_chunk_addsub.sv
// One chunk of the redundant-to-binary datapath: either sums WRDS_PER_CYC overlapping
// words plus a 2-bit carry, or subtracts a modulus chunk and a borrow from a binary chunk.
module redun_chunk_addsub
    import redun_mont_pkg::*;
#(
    parameter int WRDS_PER_CYC = 4,
    parameter int WRD_BITS     = 16
) (
    input  logic                                  add_mode,
    input  logic [WRDS_PER_CYC-1:0][WRD_BITS:0]   wrds,
    input  logic [WRDS_PER_CYC*WRD_BITS-1:0]      b_chunk,
    input  logic [WRDS_PER_CYC*WRD_BITS-1:0]      p_chunk,
    input  logic [1:0]                            cin,
    output logic [WRDS_PER_CYC*WRD_BITS-1:0]      res,
    output logic [1:0]                            cout
);

    localparam int CW = WRDS_PER_CYC * WRD_BITS;
    localparam int AW = CW + 2;

    logic [AW-1:0] wsum;
    logic [AW-1:0] ext;

    // In subtract mode the top two bits read 2'b11 exactly when the chunk borrowed.
    always_comb begin
        wsum = '0;
        for (int j = 0; j < WRDS_PER_CYC; j++)
            wsum += AW'(wrds[j]) << (j*WRD_BITS);
        if (add_mode)
            ext = wsum + AW'(cin);
        else
            ext = {2'b00, b_chunk} - {2'b00, p_chunk} - AW'(cin);
    end

    assign res  = ext[CW-1:0];
    assign cout = ext[AW-1:CW];

endmodule

// File: rtl/redun_to_bin.sv
// Exit stage of the squaring loop: collapses redundant carries chunk by chunk, then runs a
// fixed number of conditional subtractions of P to land the result in [0, P).
//   state | meaning
//   IDLE  | ready, waiting for i_val
//   CARRY | folding carries into B, one chunk per cycle
//   SUB   | conditional-subtract passes, one chunk per cycle
//   DONE  | result held until i_rdy
module redun_to_bin #(
    parameter int NUM_WRDS     = redun_mont_pkg::NUM_WRDS,
    parameter int WRD_BITS     = redun_mont_pkg::WRD_BITS,
    parameter logic [NUM_WRDS*WRD_BITS-1:0] P = redun_mont_pkg::P,
    parameter int WRDS_PER_CYC = 4,
    parameter int SUB_PASSES   = 3
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0]    i_dat,
    input  logic                               i_val,
    output logic                               o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]       o_dat,
    output logic                               o_ovf,
    output logic                               o_val,
    input  logic                               i_rdy
);
    import redun_mont_pkg::*;

    localparam int C   = NUM_WRDS / WRDS_PER_CYC;
    localparam int CW  = WRDS_PER_CYC * WRD_BITS;
    localparam int NB  = NUM_WRDS * WRD_BITS;
    localparam int CIW = (C > 1) ? $clog2(C) : 1;
    localparam int PIW = (SUB_PASSES > 1) ? $clog2(SUB_PASSES) : 1;
    localparam logic [NB:0] P2 = {P, 1'b0};

    r2b_state_t                          state;
    logic [NUM_WRDS-1:0][WRD_BITS:0]     wrds;
    logic [WRDS_PER_CYC-1:0][WRD_BITS:0] w_chunk;
    logic [NB-1:0]                       b_reg, d_reg, d_full;
    logic [CW-1:0]                       b_chunk, p_chunk, p2_chunk, res;
    logic [1:0]                          b_top, carry, cin, cout;
    logic [2:0]                          top, top2;
    logic [CIW-1:0]                      chunk;
    logic [PIW-1:0]                      pass;
    logic                                rdy, borrow, borrow2, bout, bout2;
    logic                                last_chunk, last_pass, commit, ge2;

    assign w_chunk  = wrds[int'(chunk)*WRDS_PER_CYC +: WRDS_PER_CYC];
    assign b_chunk  = b_reg[int'(chunk)*CW +: CW];
    assign p_chunk  = P[int'(chunk)*CW +: CW];
    assign p2_chunk = P2[int'(chunk)*CW +: CW];
    assign cin      = (state == ST_CARRY) ? carry : {1'b0, borrow};

    redun_chunk_addsub #(
        .WRDS_PER_CYC (WRDS_PER_CYC),
        .WRD_BITS     (WRD_BITS)
    ) u_addsub (
        .add_mode (state == ST_CARRY),
        .wrds     (w_chunk),
        .b_chunk  (b_chunk),
        .p_chunk  (p_chunk),
        .cin      (cin),
        .res      (res),
        .cout     (cout)
    );

    // Parallel B - 2P borrow chain: after a committing last pass, new B >= P iff old B >= 2P.
    assign bout2 = {1'b0, b_chunk} < ({1'b0, p2_chunk} + (CW+1)'(borrow2));
    assign bout  = cout[1];

    assign last_chunk = (chunk == CIW'(C-1));
    assign last_pass  = (pass == PIW'(SUB_PASSES-1));
    assign top        = {1'b0, b_top} - {2'b00, bout};
    assign commit     = ~top[2];
    assign top2       = {1'b0, b_top} - {2'b00, P2[NB]} - {2'b00, bout2};
    assign ge2        = ~top2[2];

    always_comb begin
        d_full = d_reg;
        d_full[int'(chunk)*CW +: CW] = res;
    end

    assign o_rdy = rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            rdy     <= 1'b1;
            o_val   <= 1'b0;
            o_ovf   <= 1'b0;
            o_dat   <= '0;
            chunk   <= '0;
            pass    <= '0;
            carry   <= '0;
            borrow  <= 1'b0;
            borrow2 <= 1'b0;
            b_top   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_val && rdy) begin
                        wrds  <= i_dat;
                        rdy   <= 1'b0;
                        carry <= '0;
                        chunk <= '0;
                        state <= ST_CARRY;
                    end
                end
                ST_CARRY: begin
                    b_reg[int'(chunk)*CW +: CW] <= res;
                    carry <= cout;
                    if (last_chunk) begin
                        b_top   <= cout;
                        chunk   <= '0;
                        pass    <= '0;
                        borrow  <= 1'b0;
                        borrow2 <= 1'b0;
                        state   <= ST_SUB;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                ST_SUB: begin
                    d_reg[int'(chunk)*CW +: CW] <= res;
                    borrow  <= bout;
                    borrow2 <= bout2;
                    if (last_chunk) begin
                        chunk   <= '0;
                        borrow  <= 1'b0;
                        borrow2 <= 1'b0;
                        if (commit) begin
                            b_reg <= d_full;
                            b_top <= top[1:0];
                        end
                        if (last_pass) begin
                            o_dat <= commit ? d_full : b_reg;
                            o_ovf <= commit & ge2;
                            o_val <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_rdy && o_val) begin
                        o_val <= 1'b0;
                        rdy   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rdy   <= 1'b1;
                    o_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redun_to_bin.sv
// Directed plus randomized checks of redun_to_bin against an integer reference model
// (value of the redundant words, then up to SUB_PASSES subtractions of P).
module tb_redun_to_bin;

    localparam int NW  = 4;
    localparam int WB  = 16;
    localparam int WPC = 2;
    localparam int SP  = 3;
    localparam logic [63:0] PM = 64'h3123_4567_89AB_CDEF;
    localparam int LAT = (1 + SP) * (NW / WPC);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NW-1:0][WB:0]  dat_in;
    logic                 val_in;
    logic                 rdy_out;
    logic [NW*WB-1:0]     dat_out;
    logic                 ovf_out;
    logic                 val_out;
    logic                 rdy_in;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    redun_to_bin #(
        .NUM_WRDS     (NW),
        .WRD_BITS     (WB),
        .P            (PM),
        .WRDS_PER_CYC (WPC),
        .SUB_PASSES   (SP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_dat (dat_in),
        .i_val (val_in),
        .o_rdy (rdy_out),
        .o_dat (dat_out),
        .o_ovf (ovf_out),
        .o_val (val_out),
        .i_rdy (rdy_in)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [71:0] value_of(input logic [NW-1:0][WB:0] w);
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < NW; i++)
            v += 72'(w[i]) << (WB*i);
        return v;
    endfunction

    task automatic ref_model(input logic [71:0] v_in, output logic [63:0] d, output logic o);
        logic [71:0] v;
        v = v_in;
        for (int k = 0; k < SP; k++)
            if (v >= 72'(PM)) v = v - 72'(PM);
        d = v[63:0];
        o = (v >= 72'(PM));
    endtask

    // mode 0: plain binary limbs, 1: carry bit set in every low word, 2: random carry bits
    task automatic encode(input logic [71:0] v, input int mode, output logic [NW-1:0][WB:0] w);
        logic [71:0] r;
        bit cy;
        r = v;
        for (int i = 0; i < NW-1; i++) begin
            cy = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
            w[i] = {1'b0, r[WB-1:0]};
            r = r >> WB;
            if (cy && r != 0) begin
                w[i] = w[i] + 17'h10000;
                r = r - 72'd1;
            end
        end
        w[NW-1] = r[WB:0];
    endtask

    task automatic run_one(input string tag, input logic [NW-1:0][WB:0] w, input int hold);
        logic [63:0] ed;
        logic        eo;
        int          cyc;
        ref_model(value_of(w), ed, eo);
        @(negedge clk);
        cyc = 0;
        while (!rdy_out && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_rdy_before"}, 72'(rdy_out), 72'd1);
        dat_in = w;
        val_in = 1'b1;
        rdy_in = (hold == 0);
        @(negedge clk);
        val_in = 1'b0;
        chk({tag, "_rdy_busy"}, 72'(rdy_out), 72'd0);
        cyc = 0;
        while (!val_out && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 72'(cyc), 72'(LAT));
        chk({tag, "_dat"}, 72'(dat_out), 72'(ed));
        chk({tag, "_ovf"}, 72'(ovf_out), 72'(eo));
        for (int k = 0; k < hold; k++) begin
            val_in = 1'b1;
            for (int i = 0; i < NW; i++) dat_in[i] = 17'($urandom);
            @(negedge clk);
            chk({tag, "_hold"}, {5'd0, val_out, rdy_out, dat_out, ovf_out}, {5'd0, 1'b1, 1'b0, ed, eo});
        end
        val_in = 1'b0;
        rdy_in = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {70'd0, val_out, rdy_out}, 72'b01);
    endtask

    initial begin
        logic [NW-1:0][WB:0] w;
        logic [63:0]         v;
        int                  seen;

        rst    = 1'b1;
        val_in = 1'b1;
        rdy_in = 1'b1;
        for (int i = 0; i < NW; i++) dat_in[i] = 17'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_state", {5'd0, val_out, rdy_out, dat_out, ovf_out}, {5'd0, 1'b0, 1'b1, 64'd0, 1'b0});
        rst    = 1'b0;
        val_in = 1'b0;
        @(negedge clk);
        chk("reset_no_capture", {70'd0, val_out, rdy_out}, 72'b01);

        w = '0;
        w[0] = 17'h10000;
        run_one("carry_w0", w, 0);

        w[0] = 17'h0CDEF; w[1] = 17'h089AB; w[2] = 17'h04567; w[3] = 17'h03123;
        run_one("exact_p", w, 0);

        encode(3*72'(PM) + 72'd5, 1, w);
        run_one("3p_plus5", w, 0);

        encode(4*72'(PM) + 72'd1, 0, w);
        run_one("4p_plus1_ovf", w, 0);

        encode(72'({$urandom, $urandom} % (4*PM)), 2, w);
        run_one("backpressure", w, 10);
        encode(72'({$urandom, $urandom} % (4*PM)), 2, w);
        run_one("after_bp", w, 0);

        // reset landing in the middle of the subtract passes
        encode(2*72'(PM) + 72'd77, 1, w);
        @(negedge clk);
        dat_in = w;
        val_in = 1'b1;
        @(negedge clk);
        val_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", {5'd0, val_out, rdy_out, dat_out, ovf_out}, {5'd0, 1'b0, 1'b1, 64'd0, 1'b0});
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (val_out) seen++;
        end
        chk("midrst_no_output", 72'(seen), 72'd0);
        encode(72'({$urandom, $urandom} % (4*PM)), 2, w);
        run_one("after_midrst", w, 0);

        for (int n = 0; n < 20; n++) begin
            v = {$urandom, $urandom} % (4*PM);
            encode(72'(v), 2, w);
            run_one($sformatf("rand%0d", n), w, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
